delay_memory_ctrl: RTL and testbench

Single-port sample memory controller for the delay-line subsystem. It sits directly downstream of the delay buffer manager and serves that block's held-request write and read ports. It arbitrates both ports onto one synchronous block RAM of memory_size words. Each access is answered with a one-cycle ack or valid pulse, and the controller optionally zero-fills the memory after reset so newly allocated delay buffers start silent.

---
 rtl/delay_memory_ctrl.sv | 132 +++++++++++++
 tb/tb_delay_memory_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_memory_ctrl.sv
// Single-port sample RAM controller serving the delay buffer manager's held write/read requests.
// Optional post-reset zero-fill sweep is compiled in with DELAY_MEM_CLEAR_EN.
module delay_memory_ctrl #(
  parameter int data_width  = 16,
  parameter int memory_size = 8192,
  localparam int addr_width = $clog2(memory_size)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_write_req,
  input  logic [addr_width-1:0] mem_write_addr,
  input  logic [data_width-1:0] mem_write_data,
  output logic                  mem_write_ack,
  input  logic                  mem_read_req,
  input  logic [addr_width-1:0] mem_read_addr,
  output logic [data_width-1:0] mem_read_data,
  output logic                  mem_read_valid,
  output logic                  ready,
  output logic                  addr_error
);

  localparam logic [addr_width:0] MEM_LIMIT = (addr_width+1)'(memory_size);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACK  = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
`ifdef DELAY_MEM_CLEAR_EN
    ST_CLEAR   = 3'd5,
`endif
    ST_HOLDOFF = 3'd4
  } state_t;

`ifdef DELAY_MEM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(memory_size - 1);
  logic [addr_width-1:0] clr_q, clr_d;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t                state_q, state_d;
  logic                  err_q, err_d;
  logic [addr_width-1:0] rd_addr_q, rd_addr_d;
  logic [data_width-1:0] rd_hold_q;
  logic [data_width-1:0] ram_dout_q;
  logic [data_width-1:0] read_word;
  logic                  ram_we;
  logic [addr_width-1:0] ram_waddr;
  logic [data_width-1:0] ram_wdata;
  logic                  wr_oob, rd_oob;

  logic [data_width-1:0] mem [memory_size];

  assign wr_oob = ({1'b0, mem_write_addr} >= MEM_LIMIT);
  assign rd_oob = ({1'b0, mem_read_addr} >= MEM_LIMIT);

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rd_addr_d = rd_addr_q;
    ram_we    = 1'b0;
    ram_waddr = mem_write_addr;
    ram_wdata = mem_write_data;
`ifdef DELAY_MEM_CLEAR_EN
    clr_d     = clr_q;
`endif
    case (state_q)
`ifdef DELAY_MEM_CLEAR_EN
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        ram_wdata = '0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == LAST_ADDR) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        // Write wins; a held read is picked up on a later pass through IDLE.
        if (mem_write_req) begin
          err_d   = wr_oob;
          ram_we  = !wr_oob;
          state_d = ST_WR_ACK;
        end else if (mem_read_req) begin
          err_d     = rd_oob;
          rd_addr_d = mem_read_addr;
          state_d   = ST_RD_ADDR;
        end
      end
      ST_WR_ACK:  state_d = ST_HOLDOFF;
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_HOLDOFF;
      ST_HOLDOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_hold_q <= '0;
`ifdef DELAY_MEM_CLEAR_EN
      clr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      rd_addr_q <= rd_addr_d;
      if (state_q == ST_RD_DATA) rd_hold_q <= read_word;
`ifdef DELAY_MEM_CLEAR_EN
      clr_q     <= clr_d;
`endif
    end
  end

  // Plain synchronous RAM: one write port, registered read output.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) mem[ram_waddr] <= ram_wdata;
    ram_dout_q <= mem[rd_addr_q];
  end

  assign read_word      = err_q ? '0 : ram_dout_q;
  assign mem_write_ack  = (state_q == ST_WR_ACK);
  assign mem_read_valid = (state_q == ST_RD_DATA);
  assign addr_error     = err_q && (mem_write_ack || mem_read_valid);
  assign mem_read_data  = mem_read_valid ? read_word : rd_hold_q;
  assign ready          = (state_q == ST_IDLE) && !reset;

endmodule

// File: tb/tb_delay_memory_ctrl.sv
// Self-checking bench for delay_memory_ctrl (memory_size=6000) against an address->sample model.
module tb_delay_memory_ctrl;
  localparam int DW = 16;
  localparam int MS = 6000;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ack, valid, ready, err;
  logic [DW-1:0] rdata;

  int checks = 0;
  int failures = 0;
  int model [int];
  int written [$];

  always #5 clk = ~clk;

  delay_memory_ctrl #(.data_width(DW), .memory_size(MS)) dut (
    .clk(clk), .reset(reset),
    .mem_write_req(wr_req), .mem_write_addr(wr_addr), .mem_write_data(wr_data),
    .mem_write_ack(ack),
    .mem_read_req(rd_req), .mem_read_addr(rd_addr),
    .mem_read_data(rdata), .mem_read_valid(valid),
    .ready(ready), .addr_error(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    repeat (hold) tick();
    chk("rst_ack", ack, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
    model.delete();
`endif
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 20000) begin tick(); n++; end
    chk(tag, ready, 1);
  endtask

  task automatic do_write(input int addr, input int data);
    int n = 0;
    bit oob = (addr >= MS);
    wr_addr = addr[AW-1:0]; wr_data = data[DW-1:0]; wr_req = 1'b1;
    do begin tick(); n++; end while (ack !== 1'b1 && n < 50);
    chk("wr_ack_seen", ack, 1);
    chk("wr_latency", n, 1);
    chk("wr_addr_error", err, oob);
    tick();
    chk("wr_ack_width", ack, 0);
    wr_req = 1'b0;
    if (!oob) begin model[addr] = data & 16'hFFFF; written.push_back(addr); end
    tick();
    chk("wr_ready_after", ready, 1);
    $display("write addr=%0d data=%04h oob=%0d", addr, data & 16'hFFFF, oob);
  endtask

  task automatic do_read(input int addr);
    int n = 0;
    bit oob = (addr >= MS);
    int exp = oob ? 0 : (model.exists(addr) ? model[addr] : 0);
    rd_addr = addr[AW-1:0]; rd_req = 1'b1;
    do begin tick(); n++; end while (valid !== 1'b1 && n < 50);
    chk("rd_valid_seen", valid, 1);
    chk("rd_latency", n, 2);
    chk("rd_data", rdata, exp);
    chk("rd_addr_error", err, oob);
    tick();
    chk("rd_valid_width", valid, 0);
    chk("rd_data_hold", rdata, exp);
    rd_req = 1'b0;
    tick();
    chk("rd_ready_after", ready, 1);
    $display("read  addr=%0d data=%04h oob=%0d", addr, rdata, oob);
  endtask

  initial begin
    int n, a, cnt;
    do_reset(3);
`ifdef DELAY_MEM_CLEAR_EN
    wait_ready("clear_initial_ready");
`else
    chk("ready_first_cycle", ready, 1);
`endif

    do_write(16'h0010, 16'h7FFF);
    do_read(16'h0010);

    // Simultaneous write and read to the same address.
    wr_addr = 13'h20; wr_data = 16'h1234; rd_addr = 13'h20;
    wr_req = 1'b1; rd_req = 1'b1; n = 0;
    tick(); n++;
    chk("sim_ack_first", ack, 1);
    chk("sim_no_valid_yet", valid, 0);
    tick(); n++;
    chk("sim_ack_width", ack, 0);
    wr_req = 1'b0;
    model[32'h20] = 16'h1234;
    do begin tick(); n++; end while (valid !== 1'b1 && n < 50);
    chk("sim_rd_valid", valid, 1);
    chk("sim_rd_latency", n, 5);
    chk("sim_rd_data", rdata, 16'h1234);
    tick();
    rd_req = 1'b0;
    tick();
    $display("simul write/read addr=32 data=%04h", rdata);

    // Out-of-range accesses, next to the last valid word.
    do_write(MS - 1, 16'h1111);
    do_write(MS, 16'hBEEF);
    do_read(MS);
    do_read(MS - 1);
    do_write(8191, 16'hCAFE);
    do_read(8191);

    // Randomized mix against the model.
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 3);
      if (r <= 1) begin
        if ($urandom_range(0, 7) == 0) a = $urandom_range(MS, 8191);
        else if (written.size() > 0 && $urandom_range(0, 2) == 0)
          a = written[$urandom_range(0, written.size() - 1)];
        else a = $urandom_range(0, MS - 1);
        do_write(a, $urandom_range(0, 65535));
      end else begin
        if (written.size() == 0 || $urandom_range(0, 7) == 0) a = $urandom_range(MS, 8191);
        else a = written[$urandom_range(0, written.size() - 1)];
        do_read(a);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset while the read is in its address phase.
    do_write(16'h0040, 16'hA5A5);
    rd_addr = 13'h40; rd_req = 1'b1;
    tick();
    chk("rdaddr_no_valid", valid, 0);
    reset = 1'b1; rd_req = 1'b0;
    tick();
    chk("rst_rdaddr_valid", valid, 0);
    chk("rst_rdaddr_ack", ack, 0);
    chk("rst_rdaddr_err", err, 0);
    chk("rst_rdaddr_ready", ready, 0);
    chk("rst_rdaddr_rdata", rdata, 0);
    reset = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
    model.delete();
    wait_ready("rst_rdaddr_clear_ready");
`else
    #1;
    chk("rst_rdaddr_ready_after", ready, 1);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rdaddr_no_late_valid", valid, 0);
    end
    do_read(16'h0040);
    do_write(16'h0041, 16'h8001);
    do_read(16'h0041);

`ifdef DELAY_MEM_CLEAR_EN
    // Held read across a full clear sweep returns the zeroed word.
    do_write(5, 16'h5555);
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_addr = 13'd5; rd_req = 1'b1;
    model.delete();
    #1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 20000) begin cnt++; tick(); end
    chk("clear_ready_low_cycles", cnt, MS);
    n = 0;
    while (valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("clear_held_rd_valid", valid, 1);
    chk("clear_held_rd_data", rdata, 0);
    tick();
    rd_req = 1'b0;
    tick();
    $display("clear sweep ready_low=%0d held read data=%04h", cnt, rdata);
    // Reset mid-sweep restarts the count.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 20000) begin cnt++; tick(); end
    chk("clear_restart_low_cycles", cnt, MS);
    $display("clear restart ready_low=%0d", cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
